// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared reset PC, FSM encoding and length decode for pc_gen
package pc_gen_pkg;

    localparam logic [31:0] PCG_RESET_PC = 32'h3000_0000;

    typedef enum logic {
        PCG_RUN   = 1'b0,
        PCG_CROSS = 1'b1
    } pcg_state_e;

    // Takes only the low two bits of a halfword: 2'b11 marks a 32-bit instruction.
    function automatic logic pcg_is_32bit(input logic [1:0] hw_lo);
        return hw_lo == 2'b11;
    endfunction

endpackage

// File: rtl/pc_redirect_pend.sv
// rtl/pc_redirect_pend.sv - holds a flush target that arrived while the icache was busy
module pc_redirect_pend
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] target_i,
    output logic            pend_valid_o,
    output logic [XLEN-1:0] pend_pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Capture wins over clear so a newer flush always overwrites the held target.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        if (capture_i) begin
            valid_d = 1'b1;
            pc_d    = target_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

    assign pend_valid_o = valid_q;
    assign pend_pc_o    = pc_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC / icache address generator; PC_GEN_RVC_EN enables compressed sequencing
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PCG_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_valid_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            bpu_pc_valid_i,
    input  logic [XLEN-1:0] bpu_pc_i,
    input  logic            inst_valid_i,
    input  logic [31:0]     inst_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] fetch_addr_o,
    output logic            pc_valid_o,
    output logic            cross_refill_o
);

`ifdef PC_GEN_RVC_EN
    localparam logic [XLEN-1:0] TGT_MASK = ~XLEN'(1);
`else
    localparam logic [XLEN-1:0] TGT_MASK = ~XLEN'(3);
`endif

    logic [XLEN-1:0] pc_q;
    pcg_state_e      state_q;
    logic            pc_valid_q;

    logic            adv;
    logic            capture;
    logic            flush_now;
    logic            release_pend;
    logic            pend_valid;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic            go_cross;

    assign adv          = inst_valid_i & ~stall_i;
    // A flush while stalled with no icache data cannot kill anything yet; park it.
    assign capture      = flush_valid_i & stall_i & ~inst_valid_i;
    assign flush_now    = flush_valid_i & ~capture;
    assign release_pend = pend_valid & ~stall_i & ~flush_valid_i;
    assign redirect_pc  = (flush_now ? flush_pc_i : pend_pc) & TGT_MASK;

    pc_redirect_pend #(
        .XLEN(XLEN)
    ) u_pend (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (capture),
        .clear_i     (~stall_i | flush_valid_i),
        .target_i    (flush_pc_i),
        .pend_valid_o(pend_valid),
        .pend_pc_o   (pend_pc)
    );

`ifdef PC_GEN_RVC_EN
    logic [1:0] len_bits;
    logic       is32;
    logic       unused_inst_bits;

    assign len_bits         = pc_q[1] ? inst_data_i[17:16] : inst_data_i[1:0];
    assign is32             = pcg_is_32bit(len_bits);
    assign unused_inst_bits = ^{inst_data_i[31:18], inst_data_i[15:2]};
    assign go_cross         = (state_q == PCG_RUN) & pc_q[1] & is32;
    assign seq_pc           = pc_q + (((state_q == PCG_CROSS) || is32) ? XLEN'(4) : XLEN'(2));
    assign cross_refill_o   = (state_q == PCG_CROSS);
`else
    logic unused_inst_bits;

    assign unused_inst_bits = ^inst_data_i;
    assign go_cross         = 1'b0;
    assign seq_pc           = pc_q + XLEN'(4);
    assign cross_refill_o   = 1'b0;
`endif

    assign next_pc = bpu_pc_valid_i ? (bpu_pc_i & TGT_MASK) : seq_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= PCG_RUN;
            pc_valid_q <= 1'b0;
        end else if (flush_now || release_pend) begin
            pc_q       <= redirect_pc;
            state_q    <= PCG_RUN;
            pc_valid_q <= 1'b0;
        end else if (capture || pend_valid) begin
            state_q    <= PCG_RUN;
            pc_valid_q <= 1'b0;
        end else begin
            pc_valid_q <= 1'b1;
            if (adv) begin
                if (go_cross) begin
                    state_q <= PCG_CROSS;
                end else begin
                    state_q <= PCG_RUN;
                    pc_q    <= next_pc;
                end
            end
        end
    end

    assign pc_o         = pc_q;
    assign pc_valid_o   = pc_valid_q;
    assign fetch_addr_o = (pc_q & ~XLEN'(3)) + ((state_q == PCG_CROSS) ? XLEN'(4) : XLEN'(0));

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - vector table, corner sequences and randomized model check for pc_gen
module tb_pc_gen;

`ifdef PC_GEN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_valid_i, bpu_pc_valid_i, inst_valid_i;
    logic [31:0] flush_pc_i, bpu_pc_i, inst_data_i;
    logic [31:0] pc_o, fetch_addr_o;
    logic        pc_valid_o, cross_refill_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_valid_i (flush_valid_i),
        .flush_pc_i    (flush_pc_i),
        .bpu_pc_valid_i(bpu_pc_valid_i),
        .bpu_pc_i      (bpu_pc_i),
        .inst_valid_i  (inst_valid_i),
        .inst_data_i   (inst_data_i),
        .pc_o          (pc_o),
        .fetch_addr_o  (fetch_addr_o),
        .pc_valid_o    (pc_valid_o),
        .cross_refill_o(cross_refill_o)
    );

    typedef struct {
        logic        st, iv, fv;
        logic [31:0] fpc;
        logic        bv;
        logic [31:0] bpc, data, e_pc;
        logic        e_valid, e_cross;
        logic [31:0] e_fetch;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic st, input logic iv, input logic fv, input logic [31:0] fpc,
                                input logic bv, input logic [31:0] bpc, input logic [31:0] data,
                                input logic [31:0] e_pc, input logic e_valid, input logic e_cross,
                                input logic [31:0] e_fetch);
        vec_t v;
        v.st = st; v.iv = iv; v.fv = fv; v.fpc = fpc; v.bv = bv; v.bpc = bpc; v.data = data;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_cross = e_cross; v.e_fetch = e_fetch;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_cross, input logic [31:0] e_fetch);
        check({tag, " pc_o"}, pc_o, e_pc);
        check({tag, " pc_valid_o"}, 32'(pc_valid_o), 32'(e_valid));
        check({tag, " cross_refill_o"}, 32'(cross_refill_o), 32'(e_cross));
        check({tag, " fetch_addr_o"}, fetch_addr_o, e_fetch);
    endtask

    task automatic drive(input logic st, input logic iv, input logic fv, input logic [31:0] fpc,
                         input logic bv, input logic [31:0] bpc, input logic [31:0] data);
        stall_i = st; inst_valid_i = iv; flush_valid_i = fv; flush_pc_i = fpc;
        bpu_pc_valid_i = bv; bpu_pc_i = bpc; inst_data_i = data;
    endtask

    // Reference: architectural PC, refill flag and parked redirect, advanced once per clock.
    logic [31:0] m_pc, m_pend_pc;
    bit          m_cross, m_valid, m_pend;

    function automatic logic [31:0] tgt(input logic [31:0] a);
        return RVC ? (a / 2) * 2 : (a / 4) * 4;
    endfunction

    task automatic model_edge();
        logic [15:0] hw;
        bit          long_insn;
        if (flush_valid_i && stall_i && !inst_valid_i) begin
            m_pend = 1; m_pend_pc = flush_pc_i; m_cross = 0; m_valid = 0;
        end else if (flush_valid_i) begin
            m_pc = tgt(flush_pc_i); m_pend = 0; m_cross = 0; m_valid = 0;
        end else if (m_pend) begin
            m_valid = 0;
            if (!stall_i) begin
                m_pc = tgt(m_pend_pc); m_pend = 0;
            end
        end else begin
            m_valid = 1;
            if (inst_valid_i && !stall_i) begin
                hw        = (m_pc % 4 == 2) ? inst_data_i[31:16] : inst_data_i[15:0];
                long_insn = (hw % 4) == 3;
                if (!RVC) begin
                    m_pc = bpu_pc_valid_i ? tgt(bpu_pc_i) : m_pc + 4;
                end else if (!m_cross && long_insn && (m_pc % 4 == 2)) begin
                    m_cross = 1;
                end else begin
                    m_pc    = bpu_pc_valid_i ? tgt(bpu_pc_i) : m_pc + ((m_cross || long_insn) ? 4 : 2);
                    m_cross = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0, RST_PC, 1, 0, RST_PC);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 32'h0000_0013, 32'h3000_0004, 1, 0, 32'h3000_0004);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 32'h0013_4501, RVC ? 32'h3000_0006 : 32'h3000_0008, 1, 0,
                      RVC ? 32'h3000_0004 : 32'h3000_0008);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 32'h0513_4501, RVC ? 32'h3000_0006 : 32'h3000_000C, 1, RVC,
                      RVC ? 32'h3000_0008 : 32'h3000_000C);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 32'h0000_0001, RVC ? 32'h3000_000A : 32'h3000_0010, 1, 0,
                      RVC ? 32'h3000_0008 : 32'h3000_0010);
        vecs[5]  = mk(0, 1, 1, 32'h100, 1, 32'h200, 32'h13, 32'h100, 0, 0, 32'h100);
        vecs[6]  = mk(0, 1, 0, 0, 1, 32'h203, 32'h13, RVC ? 32'h202 : 32'h200, 1, 0, 32'h200);
        vecs[7]  = mk(1, 0, 1, 32'h8000_0100, 0, 0, 32'h13, RVC ? 32'h202 : 32'h200, 0, 0, 32'h200);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 32'h13, RVC ? 32'h202 : 32'h200, 0, 0, 32'h200);
        vecs[9]  = mk(1, 0, 1, 32'h8000_0201, 0, 0, 32'h13, RVC ? 32'h202 : 32'h200, 0, 0, 32'h200);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 32'h13, 32'h8000_0200, 0, 0, 32'h8000_0200);
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 32'h13, 32'h8000_0204, 1, 0, 32'h8000_0204);
        vecs[12] = mk(1, 1, 0, 0, 1, 32'h500, 32'h13, 32'h8000_0204, 1, 0, 32'h8000_0204);
        vecs[13] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h13, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 32'h13, 32'h0, 1, 0, 32'h0);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 32'h0000_4501, RVC ? 32'h2 : 32'h4, 1, 0, RVC ? 32'h0 : 32'h4);
        vecs[16] = mk(0, 1, 0, 0, 0, 0, 32'h0513_4501, RVC ? 32'h2 : 32'h8, 1, RVC, RVC ? 32'h4 : 32'h8);
        vecs[17] = mk(1, 1, 1, 32'h40, 0, 0, 32'h0, 32'h40, 0, 0, 32'h40);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", RST_PC, 0, 0, RST_PC);
        rst = 1'b0;
        #1;
        check_all("post-release", RST_PC, 0, 0, RST_PC);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].iv, vecs[i].fv, vecs[i].fpc, vecs[i].bv, vecs[i].bpc, vecs[i].data);
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_cross, vecs[i].e_fetch);
        end

        // Enter the refill again, then hit reset between edges.
        drive(0, 1, 0, 0, 0, 0, 32'h0000_4501);
        @(posedge clk);
        #1;
        check_all("pre-cross", RVC ? 32'h42 : 32'h44, 1, 0, RVC ? 32'h40 : 32'h44);
        drive(0, 1, 0, 0, 0, 0, 32'h0003_4501);
        @(posedge clk);
        #1;
        check_all("in-cross", RVC ? 32'h42 : 32'h48, 1, RVC, RVC ? 32'h44 : 32'h48);
        #2;
        rst = 1'b1;
        #1;
        check_all("async-reset", RST_PC, 0, 0, RST_PC);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        m_pc = RST_PC; m_pend_pc = '0; m_cross = 0; m_valid = 0; m_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom, $urandom_range(0, 4) == 0, $urandom, $urandom);
            @(posedge clk);
            #1;
            model_edge();
            check_all($sformatf("rand%0d", n), m_pc, m_valid, m_cross,
                      (m_pc / 4) * 4 + (m_cross ? 32'h4 : 32'h0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
